// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter that runs each SRAM access as a fixed
// setup / write-pulse / hold (or read) sequence. Every output comes from a register.
module sram_arbiter #(
  parameter int AW       = 2,
  parameter int DW       = 4,
  parameter int WR_PULSE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          done0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);
  localparam int CW = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, WRITE, HOLD, READ, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          last_reg, last_next;
  logic          who_reg, who_next;
  logic          cmd_we_reg, cmd_we_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic [DW-1:0] rdata_reg, rdata_next;
  logic          we_reg, we_next;
  logic          gnt0_reg, gnt0_next, gnt1_reg, gnt1_next;
  logic          done0_reg, done0_next, done1_reg, done1_next;
  logic          pick;

  // A lone request always wins; under contention the requester not served last wins.
  assign pick = (req0 && req1) ? ~last_reg : req1;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    last_next   = last_reg;
    who_next    = who_reg;
    cmd_we_next = cmd_we_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    rdata_next  = rdata_reg;
    we_next     = 1'b0;
    gnt0_next   = 1'b0;
    gnt1_next   = 1'b0;
    done0_next  = 1'b0;
    done1_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          who_next    = pick;
          cmd_we_next = pick ? we1 : we0;
          addr_next   = pick ? addr1 : addr0;
          wdata_next  = pick ? wdata1 : wdata0;
          gnt0_next   = ~pick;
          gnt1_next   = pick;
          state_next  = SETUP;
        end
      end
      SETUP: begin
        cnt_next = '0;
        if (cmd_we_reg) begin
          we_next    = 1'b1;
          state_next = WRITE;
        end else begin
          state_next = READ;
        end
      end
      WRITE: begin
        if (cnt_reg == CW'(WR_PULSE - 1)) begin
          state_next = HOLD;
        end else begin
          cnt_next = cnt_reg + 1'b1;
          we_next  = 1'b1;
        end
      end
      HOLD: begin
        done0_next = ~who_reg;
        done1_next = who_reg;
        state_next = DONE;
      end
      READ: begin
        rdata_next = mem_rdata;
        done0_next = ~who_reg;
        done1_next = who_reg;
        state_next = DONE;
      end
      DONE: begin
        last_next  = who_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      last_reg   <= 1'b1;
      who_reg    <= 1'b0;
      cmd_we_reg <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      we_reg     <= 1'b0;
      gnt0_reg   <= 1'b0;
      gnt1_reg   <= 1'b0;
      done0_reg  <= 1'b0;
      done1_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      last_reg   <= last_next;
      who_reg    <= who_next;
      cmd_we_reg <= cmd_we_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      rdata_reg  <= rdata_next;
      we_reg     <= we_next;
      gnt0_reg   <= gnt0_next;
      gnt1_reg   <= gnt1_next;
      done0_reg  <= done0_next;
      done1_reg  <= done1_next;
    end
  end

  assign gnt0      = gnt0_reg;
  assign gnt1      = gnt1_reg;
  assign done0     = done0_reg;
  assign done1     = done1_reg;
  assign rdata     = rdata_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_we    = we_reg;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic, checked every
// cycle against a timing-arithmetic model of the access schedule.
module tb_sram_arbiter;
  localparam int WP = 1;

  logic       clk;
  logic       rst_n;
  logic       req0, we0, req1, we1;
  logic [1:0] addr0, addr1;
  logic [3:0] wdata0, wdata1;
  logic       gnt0, done0, gnt1, done1;
  logic [3:0] rdata, mem_wdata, mem_rdata;
  logic [1:0] mem_addr;
  logic       mem_we;

  // second instance with a 3-cycle write pulse
  logic       rst_b_n, req_b, we_b, req_b1, we_b1;
  logic [1:0] addr_b, addr_b1, mem_addr_b;
  logic [3:0] wdata_b, wdata_b1, rdata_b, mem_wdata_b, mem_rdata_b;
  logic       gnt_b, done_b, gnt_b1, done_b1, mem_we_b;

  sram_arbiter #(.AW(2), .DW(4), .WR_PULSE(WP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  sram_arbiter #(.AW(2), .DW(4), .WR_PULSE(3)) dut_b (
    .clk(clk), .rst_n(rst_b_n),
    .req0(req_b), .we0(we_b), .addr0(addr_b), .wdata0(wdata_b), .gnt0(gnt_b), .done0(done_b),
    .req1(req_b1), .we1(we_b1), .addr1(addr_b1), .wdata1(wdata_b1), .gnt1(gnt_b1), .done1(done_b1),
    .rdata(rdata_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b),
    .mem_rdata(mem_rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // latch SRAMs: the addressed word follows write data while we is high
  logic [3:0] sram [4];
  logic [3:0] sram_b [4];
  assign mem_rdata   = sram[mem_addr];
  assign mem_rdata_b = sram_b[mem_addr_b];
  initial forever begin
    @(mem_we or mem_addr or mem_wdata);
    if (mem_we) sram[mem_addr] = mem_wdata;
  end
  initial forever begin
    @(mem_we_b or mem_addr_b or mem_wdata_b);
    if (mem_we_b) sram_b[mem_addr_b] = mem_wdata_b;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an access sampled in idle cycle T has gnt at T+1, write
  // pulse over T+2..T+1+WP, done at T+3 (+WP for writes), next sample at done+1.
  int         cyc = 0;
  int         free_cyc = 0;
  int         t_start = 0;
  int         rel;
  bit         act = 0;
  bit         m_last = 1;
  bit         m_who, m_we;
  logic [1:0] m_addr;
  logic [3:0] m_wdata;
  logic [3:0] refmem [4];
  bit         vld [4];
  bit         e_gnt0, e_gnt1, e_done0, e_done1, e_we;
  logic [1:0] e_addr;
  logic [3:0] e_wdata, e_rdata;
  bit         rd_known = 1;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    e_gnt0 = 0; e_gnt1 = 0; e_done0 = 0; e_done1 = 0; e_we = 0;
    if (!rst_n) begin
      if (act && m_we && (cyc - 1 >= t_start + 2) && (cyc - 1 <= t_start + 1 + WP))
        vld[m_addr] = 0;
      act = 0; m_last = 1; free_cyc = cyc;
      e_addr = 0; e_wdata = 0; e_rdata = 0; rd_known = 1;
    end else begin
      if ((cyc - 1 >= free_cyc) && (req0 || req1)) begin
        m_who   = (req0 && req1) ? !m_last : req1;
        m_we    = m_who ? we1 : we0;
        m_addr  = m_who ? addr1 : addr0;
        m_wdata = m_who ? wdata1 : wdata0;
        t_start = cyc - 1;
        act     = 1;
        m_last  = m_who;
        free_cyc = t_start + 4 + (m_we ? WP : 0);
      end
      if (act) begin
        rel = cyc - t_start;
        if (rel == 1) begin
          e_gnt0 = !m_who; e_gnt1 = m_who;
          e_addr = m_addr; e_wdata = m_wdata;
        end
        if (m_we && rel >= 2 && rel <= 1 + WP) begin
          e_we = 1;
          if (rel == 2) begin refmem[m_addr] = m_wdata; vld[m_addr] = 1; end
        end
        if (rel == 3 + (m_we ? WP : 0)) begin
          e_done0 = !m_who; e_done1 = m_who;
          if (!m_we) begin e_rdata = refmem[m_addr]; rd_known = vld[m_addr]; end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      chk("gnt0", gnt0, e_gnt0);
      chk("gnt1", gnt1, e_gnt1);
      chk("done0", done0, e_done0);
      chk("done1", done1, e_done1);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      if (rd_known) chk("rdata", rdata, e_rdata);
      chk("exclusive", {gnt0 & gnt1, done0 & done1}, 0);
    end
  end

  function automatic logic sig(input int w);
    case (w)
      0: return gnt0;
      1: return gnt1;
      2: return done0;
      3: return done1;
      default: return mem_we;
    endcase
  endfunction

  task automatic wait_for(input int w, input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig(w) && n < 40);
    if (!sig(w)) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timeout after %0d cycles, required event never seen", nm, n);
    end
  endtask

  int n;
  int gq[$];
  bit re0, re1, stop, busy0, busy1, cool0, cool1;
  logic [8:0] pat_we, pat_done;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; req0 = 1; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    rst_b_n = 0; req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
    req_b1 = 0; we_b1 = 0; addr_b1 = 0; wdata_b1 = 0;

    // 1. reset with req0 held
    repeat (2) @(negedge clk);
    chk("t1_rst_gnt0", gnt0, 0);
    chk("t1_rst_mem_we", mem_we, 0);
    chk("t1_rst_rdata", rdata, 0);
    rst_n = 1; rst_b_n = 1;
    wait_for(0, "t1_gnt0", n);
    chk("t1_gnt_latency", n, 1);
    wait_for(2, "t1_done0", n);
    chk("t1_read_latency", n, 2);
    req0 = 0;

    // 2. write 4'hA to word 2
    @(negedge clk);
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 2; wdata0 = 4'hA;
    @(negedge clk); chk("t2_gnt0", gnt0, 1); chk("t2_we_early", mem_we, 0);
    @(negedge clk); chk("t2_we", mem_we, 1); chk("t2_addr", mem_addr, 2); chk("t2_data", mem_wdata, 'hA);
    @(negedge clk); chk("t2_we_hold", mem_we, 0); chk("t2_addr_hold", mem_addr, 2);
    chk("t2_data_hold", mem_wdata, 'hA); chk("t2_done_early", done0, 0);
    @(negedge clk); chk("t2_done0", done0, 1);
    req0 = 0;

    // 3. read word 2 back through requester 1
    @(negedge clk);
    @(negedge clk);
    req1 = 1; we1 = 0; addr1 = 2;
    @(negedge clk); chk("t3_gnt1", gnt1, 1);
    @(negedge clk); chk("t3_done_early", done1, 0);
    @(negedge clk); chk("t3_done1", done1, 1); chk("t3_rdata", rdata, 'hA);
    req1 = 0;
    @(negedge clk); chk("t3_rdata_held", rdata, 'hA);

    // 4. continuous contention out of reset
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    req0 = 1; we0 = 1; addr0 = 0; wdata0 = 4'h3;
    req1 = 1; we1 = 0; addr1 = 2; wdata1 = 4'h0;
    re0 = 0; re1 = 0; stop = 0;
    for (int c = 0; c < 80 && !(stop && !req0 && !req1); c++) begin
      @(negedge clk);
      if (gnt0) gq.push_back(0);
      if (gnt1) gq.push_back(1);
      if (gq.size() >= 4) stop = 1;
      if (done0) begin req0 = 0; re0 = !stop; end
      else if (re0) begin re0 = 0; req0 = 1; we0 = 1'($urandom_range(0, 1)); addr0 = 2'($urandom_range(0, 3)); wdata0 = 4'($urandom_range(0, 15)); end
      if (done1) begin req1 = 0; re1 = !stop; end
      else if (re1) begin re1 = 0; req1 = 1; we1 = 1'($urandom_range(0, 1)); addr1 = 2'($urandom_range(0, 3)); wdata1 = 4'($urandom_range(0, 15)); end
    end
    chk("t4_grant_count", int'(gq.size() >= 4), 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t4_order%0d", i), (i < gq.size()) ? gq[i] : -1, i % 2);
    req0 = 0; req1 = 0;

    // 5. reset during a write
    @(negedge clk);
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 1; wdata0 = 4'h5;
    wait_for(4, "t5_we", n);
    rst_n = 0; req0 = 0;
    @(negedge clk);
    chk("t5_we_off", mem_we, 0); chk("t5_no_done", done0, 0);
    rst_n = 1;
    req0 = 1; we0 = 0; addr0 = 3;
    req1 = 1; we1 = 0; addr1 = 0;
    @(negedge clk);
    chk("t5_gnt0_first", gnt0, 1); chk("t5_gnt1_later", gnt1, 0);
    wait_for(2, "t5_done0", n); req0 = 0;
    wait_for(3, "t5_done1", n); req1 = 0;

    // random traffic against the model
    busy0 = 0; busy1 = 0; cool0 = 0; cool1 = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done0) begin req0 = 0; busy0 = 0; cool0 = 1; end
      else if (busy0) begin if (gnt0 && $urandom_range(0, 3) == 0) req0 = 0; end
      else if (cool0) cool0 = 0;
      else if ($urandom_range(0, 2) == 0) begin
        busy0 = 1; req0 = 1; we0 = 1'($urandom_range(0, 1));
        addr0 = 2'($urandom_range(0, 3)); wdata0 = 4'($urandom_range(0, 15));
      end
      if (done1) begin req1 = 0; busy1 = 0; cool1 = 1; end
      else if (busy1) begin if (gnt1 && $urandom_range(0, 3) == 0) req1 = 0; end
      else if (cool1) cool1 = 0;
      else if ($urandom_range(0, 2) == 0) begin
        busy1 = 1; req1 = 1; we1 = 1'($urandom_range(0, 1));
        addr1 = 2'($urandom_range(0, 3)); wdata1 = 4'($urandom_range(0, 15));
      end
    end
    for (int c = 0; c < 40 && (busy0 || busy1); c++) begin
      @(negedge clk);
      if (done0) begin req0 = 0; busy0 = 0; end
      if (done1) begin req1 = 0; busy1 = 0; end
    end
    chk("rand_drained", int'(busy0 || busy1), 0);

    // 6. three-cycle write pulse on the second instance, then read back
    @(negedge clk);
    req_b = 1; we_b = 1; addr_b = 3; wdata_b = 4'h5;
    pat_we = '0; pat_done = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      pat_we[k] = mem_we_b;
      pat_done[k] = done_b;
      if (done_b) req_b = 0;
    end
    chk("t6_we_pattern", pat_we, 9'h01C);
    chk("t6_done_pattern", pat_done, 9'h040);
    req_b = 1; we_b = 0;
    repeat (3) @(negedge clk);
    chk("t6_read_done", done_b, 1);
    chk("t6_read_data", rdata_b, 'h5);
    req_b = 0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
